pwm_pin_dac: RTL and testbench
==============================

Name: pwm_pin_dac

Overview:
- Output stage directly downstream of the FM/log-sine frequency generator.
- Consumes its 16-bit two's-complement sample stream and drives a single PWM pin through an external RC filter.
- A soft-start/soft-mute state machine ramps the pin duty between 0% and mid-scale, so enable/disable produces no click.
- New samples are taken once per PWM period.

Parameters:
- PWM_BITS, 10: PWM counter and duty resolution. Period is 2^PWM_BITS clk cycles. Legal range 4..12.
- RAMP_STEP, 1: duty increment/decrement applied per PWM period while ramping. Must be at least 1 and at most 2^(PWM_BITS-1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 requests audio output, 0 requests mute.
- sample_in  in  16  two's-complement sample from the frequency generator. Sampled only at period boundaries.
- pwm_out  out  1  registered PWM pin drive.
- period_strobe  out  1  high during the last cycle of each PWM period (cnt == 2^PWM_BITS-1) while state != IDLE.
- state  out  2  current state: IDLE=0, RAMP_UP=1, RUN=2, MUTE=3.

Behaviour:
- Reset (asynchronous, rst_n=0) drives state=IDLE, cnt=0, duty=0, pwm_out=0, period_strobe=0. These values hold while rst_n=0. Reset asserted mid-operation aborts immediately, with no ramp-down.
- Definitions:
  - MID = 2^(PWM_BITS-1).
  - u = sample_in ^ 16'h8000 (offset binary).
  - target = u[15:16-PWM_BITS].
  - Boundary = a rising edge at which cnt == 2^PWM_BITS-1 and state != IDLE.
- Counter cnt (PWM_BITS wide):
  - Held at 0 in IDLE.
  - Otherwise increments by 1 each clk and wraps from 2^PWM_BITS-1 to 0.
- pwm_out is registered: pwm_out(t+1) = (state(t) != IDLE) && (cnt(t) < duty(t)).
- duty (PWM_BITS wide) changes only at a boundary, or at reset. A new duty therefore takes effect from cnt=0 of the next period.
- IDLE:
  - pwm_out=0, duty=0.
  - enable=1 at edge t gives state=RAMP_UP at t+1, with cnt=0 at t+1.
- RAMP_UP, at each boundary:
  - If enable=0: go to MUTE. duty is unchanged at this boundary.
  - Else if duty+RAMP_STEP >= MID: duty=MID, go to RUN.
  - Else: duty += RAMP_STEP.
- RUN, at each boundary:
  - If enable=0: go to MUTE. duty is unchanged at this boundary.
  - Else: duty = target. The sample is captured on that edge.
- MUTE, at each boundary:
  - If enable=1: go to RAMP_UP. duty is unchanged. The ramp continues from the current duty, not from 0.
  - Else if duty <= RAMP_STEP: duty=0, go to IDLE. cnt is forced to 0 on the same edge.
  - Else: duty -= RAMP_STEP.
- enable is ignored between boundaries, except in IDLE.
- RUN with target above MID ramps down over ceil(duty/RAMP_STEP) periods.
- Arithmetic:
  - Unsigned. Intermediate sums are PWM_BITS+1 wide, so they cannot overflow.
  - target never exceeds 2^PWM_BITS-1, so 100% duty is unreachable by design.
- sample_in outside boundaries has no effect. No handshake: the upstream generator runs freely.

Test Plan:
All scenarios use PWM_BITS=4, RAMP_STEP=1, MID=8, period 16 cycles.

1. Reset, hold enable=0 for 100 cycles:
   - state=0, pwm_out=0, period_strobe=0 throughout.
   - cnt stays 0.
2. Soft start:
   - Assert enable.
   - state=1 for the next 8 periods; duty goes 1,2,…,8; pwm_out high for duty cycles per period.
   - At the 8th boundary: state=2, duty=8.
3. RUN sample mapping:
   - sample_in = 0x0000 → duty 8, 8 high/8 low.
   - sample_in = 0x7FFF → duty 15.
   - sample_in = 0x8000 → duty 0, pwm_out stays low.
   - sample_in = 0xC000 → duty 4.
   - Each value applies from the period after capture.
4. Soft mute:
   - In RUN with duty 15, drop enable.
   - First boundary: state=3, duty 15.
   - Then 14,…,1,0: state=0 at the boundary reaching 0, cnt=0.
5. Re-enable mid-ramp:
   - During MUTE at duty 5, raise enable.
   - Next boundary: state=1, duty 5.
   - Then 6,7,8 → RUN.
   - Also drop enable in RAMP_UP at duty 3 → MUTE, then 3,2,1,0 → IDLE.
6. Asynchronous reset in RUN mid-period (cnt=7):
   - pwm_out, period_strobe, state drop to 0 without waiting for clk.
   - After release with enable=1: full ramp from duty 0 as in scenario 2.

Source files
------------

// File: rtl/pwm_pin_dac.sv
// pwm_pin_dac: PWM pin driver for the frequency generator's sample stream,
// with soft-start/soft-mute ramping of the duty between 0 and mid-scale.
module pwm_pin_dac #(
  parameter int PWM_BITS  = 10,
  parameter int RAMP_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] sample_in,
  output logic        pwm_out,
  output logic        period_strobe,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {IDLE = 2'd0, RAMP_UP = 2'd1, RUN = 2'd2, MUTE = 2'd3} state_e;
  localparam logic [PWM_BITS:0] MID  = (PWM_BITS+1)'(2 ** (PWM_BITS - 1));
  localparam logic [PWM_BITS:0] STEP = (PWM_BITS+1)'(RAMP_STEP);
  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d, duty_q, duty_d, target;
  logic [PWM_BITS:0]   up;
  logic [15:0]         u;
  logic                boundary, pwm_q, pwm_d, unused_lsbs;
  // Offset binary puts silence at mid-scale; only the top bits set the duty.
  assign u           = sample_in ^ 16'h8000;
  assign target      = u[15 -: PWM_BITS];
  assign unused_lsbs = ^u[15-PWM_BITS:0];
  assign up          = {1'b0, duty_q} + STEP;
  assign boundary    = (state_q != IDLE) && (&cnt_q);
  assign pwm_d       = (state_q != IDLE) && (cnt_q < duty_q);
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    cnt_d   = (state_q == IDLE) ? '0 : cnt_q + PWM_BITS'(1);
    case (state_q)
      IDLE: begin
        duty_d  = '0;
        state_d = enable ? RAMP_UP : IDLE;
      end
      RAMP_UP: if (boundary) begin
        state_d = !enable ? MUTE : (up >= MID) ? RUN : RAMP_UP;
        duty_d  = !enable ? duty_q : (up >= MID) ? MID[PWM_BITS-1:0] : up[PWM_BITS-1:0];
      end
      RUN: if (boundary) begin
        state_d = enable ? RUN : MUTE;
        duty_d  = enable ? target : duty_q;
      end
      MUTE: if (boundary) begin
        // Re-enable resumes the ramp from wherever the fade-out had reached.
        if (enable) state_d = RAMP_UP;
        else if ({1'b0, duty_q} <= STEP) begin
          state_d = IDLE;
          duty_d  = '0;
          cnt_d   = '0;
        end else duty_d = duty_q - STEP[PWM_BITS-1:0];
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
    end
  end
  assign pwm_out       = pwm_q;
  assign period_strobe = boundary;
  assign state         = state_q;
endmodule

// File: tb/tb_pwm_pin_dac.sv
// tb_pwm_pin_dac: checks pwm_pin_dac (PWM_BITS=4, RAMP_STEP=1) against a
// period-level behavioural model plus constant expectations from the test plan.
module tb_pwm_pin_dac;
  localparam int PB   = 4;
  localparam int P    = 16;
  localparam int MID  = 8;
  localparam int STEP = 1;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] sample_in = 16'h0000;
  logic        pwm_out, period_strobe;
  logic [1:0]  state;
  int n_checks = 0;
  int n_fail = 0;
  int ms = 0, mc = 0, md = 0;
  bit mpwm = 1'b0, mstrobe = 1'b0;

  pwm_pin_dac #(.PWM_BITS(PB), .RAMP_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .pwm_out(pwm_out), .period_strobe(period_strobe), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // One clock edge; the model applies the rules to the inputs seen at that edge.
  task automatic tick();
    int ns, nd;
    @(posedge clk);
    if (!rst_n) begin
      ms = 0; mc = 0; md = 0; mpwm = 1'b0;
    end else begin
      ns = ms;
      nd = md;
      mpwm = (ms != 0) && (mc < md);
      if (ms == 0) ns = enable ? 1 : 0;
      else if (mc == P - 1) begin
        case (ms)
          1: begin
            nd = !enable ? md : ((md + STEP < MID) ? md + STEP : MID);
            ns = !enable ? 3 : ((nd == MID) ? 2 : 1);
          end
          2: begin
            nd = enable ? int'((sample_in ^ 16'h8000) >> (16 - PB)) : md;
            ns = enable ? 2 : 3;
          end
          default: begin
            nd = enable ? md : ((md > STEP) ? md - STEP : 0);
            ns = enable ? 1 : ((nd == 0) ? 0 : 3);
          end
        endcase
      end
      mc = (ms == 0 || ns == 0) ? 0 : (mc + 1) % P;
      ms = ns;
      md = nd;
    end
    mstrobe = (ms != 0) && (mc == P - 1);
    #1;
  endtask

  // Runs one PWM period: high-cycle count, state after the first edge, and
  // the number of cycles where the pins disagreed with the model.
  task automatic run_period(input bit junk, output int hi, output logic [1:0] st0, output int diffs);
    hi = 0; diffs = 0; st0 = 2'd0;
    for (int i = 0; i < P; i++) begin
      tick();
      if (i == 0) st0 = state;
      if (pwm_out === 1'b1) hi++;
      if ({state, pwm_out, period_strobe} !== {2'(ms), mpwm, mstrobe}) diffs++;
      if (junk && i == 3) sample_in = 16'($urandom);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; sample_in = 16'h0000;
    repeat (3) tick();
    n_checks++;
    if ({state, pwm_out, period_strobe} !== 4'b0) begin
      n_fail++; $display("FAIL reset_hold: got %b want 0000", {state, pwm_out, period_strobe});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_checks++;
      if ({state, pwm_out, period_strobe} !== 4'b0) begin
        n_fail++; $display("FAIL idle_quiet[%0d]: got %b want 0000", i, {state, pwm_out, period_strobe});
      end
    end
  endtask

  task automatic test_soft_start();
    int hi, d;
    logic [1:0] st0;
    enable = 1'b1;
    tick();
    n_checks++;
    if (state !== 2'd1) begin
      n_fail++; $display("FAIL start_state: got %0d want 1", state);
    end
    repeat (P - 1) tick();
    n_checks++;
    if (period_strobe !== 1'b1) begin
      n_fail++; $display("FAIL first_strobe: got %b want 1", period_strobe);
    end
    for (int k = 1; k <= MID; k++) begin
      run_period(1'b0, hi, st0, d);
      n_checks += 3;
      if (hi !== k) begin
        n_fail++; $display("FAIL ramp_hi[%0d]: got %0d want %0d", k, hi, k);
      end
      if (st0 !== ((k == MID) ? 2'd2 : 2'd1)) begin
        n_fail++; $display("FAIL ramp_state[%0d]: got %0d want %0d", k, st0, (k == MID) ? 2 : 1);
      end
      if (d !== 0) begin
        n_fail++; $display("FAIL ramp_model[%0d]: got %0d diffs want 0", k, d);
      end
    end
  endtask

  task automatic test_run_mapping();
    logic [15:0] v[10];
    int e[10];
    int hi, d;
    logic [1:0] st0;
    v[0] = 16'h0000; e[0] = 8;
    v[1] = 16'h7FFF; e[1] = 15;
    v[2] = 16'h8000; e[2] = 0;
    v[3] = 16'hC000; e[3] = 4;
    for (int i = 4; i < 9; i++) begin
      v[i] = 16'($urandom);
      e[i] = int'((v[i] ^ 16'h8000) >> 12);
    end
    v[9] = 16'h7FFF; e[9] = 15;
    for (int i = 0; i < 10; i++) begin
      sample_in = v[i];
      run_period(1'b1, hi, st0, d);
      n_checks += 3;
      if (hi !== e[i]) begin
        n_fail++; $display("FAIL map_hi[%h]: got %0d want %0d", v[i], hi, e[i]);
      end
      if (st0 !== 2'd2) begin
        n_fail++; $display("FAIL map_state[%h]: got %0d want 2", v[i], st0);
      end
      if (d !== 0) begin
        n_fail++; $display("FAIL map_model[%h]: got %0d diffs want 0", v[i], d);
      end
    end
  endtask

  task automatic test_soft_mute();
    int hi, d;
    logic [1:0] st0;
    enable = 1'b0;
    for (int dd = 15; dd >= -1; dd--) begin
      run_period(1'b0, hi, st0, d);
      n_checks += 3;
      if (hi !== ((dd < 0) ? 0 : dd)) begin
        n_fail++; $display("FAIL mute_hi[%0d]: got %0d want %0d", dd, hi, (dd < 0) ? 0 : dd);
      end
      if (st0 !== ((dd <= 0) ? 2'd0 : 2'd3)) begin
        n_fail++; $display("FAIL mute_state[%0d]: got %0d want %0d", dd, st0, (dd <= 0) ? 0 : 3);
      end
      if (d !== 0) begin
        n_fail++; $display("FAIL mute_model[%0d]: got %0d diffs want 0", dd, d);
      end
    end
  endtask

  task automatic test_reenable();
    bit en[24]  = '{1,1,1,1,1,1,0,0,1,1,1,1,1,0,0,0,0,0,0,1,0,0,0,0};
    int eh[24]  = '{1,2,3,4,5,6,6,5,5,6,7,8,8,8,7,6,5,4,3,3,3,2,1,0};
    int es[24]  = '{1,1,1,1,1,1,3,3,1,1,1,2,2,3,3,3,3,3,3,1,3,3,3,0};
    int hi, d;
    logic [1:0] st0;
    sample_in = 16'h0000;
    enable = 1'b1;
    tick();
    repeat (P - 1) tick();
    for (int r = 0; r < 24; r++) begin
      enable = en[r];
      run_period(1'b0, hi, st0, d);
      n_checks += 3;
      if (hi !== eh[r]) begin
        n_fail++; $display("FAIL reen_hi[%0d]: got %0d want %0d", r, hi, eh[r]);
      end
      if (st0 !== 2'(es[r])) begin
        n_fail++; $display("FAIL reen_state[%0d]: got %0d want %0d", r, st0, es[r]);
      end
      if (d !== 0) begin
        n_fail++; $display("FAIL reen_model[%0d]: got %0d diffs want 0", r, d);
      end
    end
  endtask

  task automatic test_async_reset();
    test_soft_start();
    sample_in = 16'h0000;
    repeat (8) tick();
    n_checks++;
    if ({state, pwm_out} !== 3'b101) begin
      n_fail++; $display("FAIL pre_reset: got %b want 101", {state, pwm_out});
    end
    #2;
    rst_n = 1'b0;
    ms = 0; mc = 0; md = 0; mpwm = 1'b0; mstrobe = 1'b0;
    #1;
    n_checks++;
    if ({state, pwm_out, period_strobe} !== 4'b0) begin
      n_fail++; $display("FAIL async_drop: got %b want 0000", {state, pwm_out, period_strobe});
    end
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if ({state, pwm_out, period_strobe} !== 4'b0) begin
      n_fail++; $display("FAIL async_hold: got %b want 0000", {state, pwm_out, period_strobe});
    end
    rst_n = 1'b1;
    test_soft_start();
  endtask

  task automatic test_random();
    int hi, d;
    logic [1:0] st0;
    for (int p = 0; p < 40; p++) begin
      enable = ($urandom_range(0, 3) != 0);
      sample_in = 16'($urandom);
      run_period(1'b1, hi, st0, d);
      n_checks++;
      if (d !== 0) begin
        n_fail++; $display("FAIL random_model[%0d]: got %0d diffs want 0", p, d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_soft_start();
    test_run_mapping();
    test_soft_mute();
    test_reenable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
